// File: rtl/uart_exchange_sequencer_pkg.sv
// Shared definitions for the UART exchange sequencer: state encoding, byte width
// and a sizing helper for the shared wait/gap counter.
package uart_exchange_sequencer_pkg;

    localparam int SEQ_BYTE_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_RX,
        ST_CHECK,
        ST_GAP,
        ST_DONE
    } seq_state_e;

    // Bits needed to hold the larger of two cycle limits; never less than 1.
    function automatic int seq_cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/uart_exchange_sequencer_counter.sv
// Cycle counter with clear, enable and a terminal flag raised on the limit-th
// counted cycle; shared by the handshake timeout and the inter-step gap.
module seq_timeout_counter
    import uart_exchange_sequencer_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         clear_i,
    input  logic         enable_i,
    input  logic [W-1:0] limit_i,
    output logic         terminal_o
);

    logic [W-1:0] count_q, count_d;

    assign terminal_o = (count_q == limit_i - W'(1));

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && !terminal_o) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_exchange_sequencer.sv
// Scripted request/response master: per step send one byte, accept one reply,
// compare against the script and count mismatches and timeouts.
module uart_exchange_sequencer
    import uart_exchange_sequencer_pkg::*;
#(
    parameter int NUM_STEPS  = 16,
    parameter int STEP_W     = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1,
    parameter int TIMEOUT    = 2000000,
    parameter int GAP_CYCLES = 0,
    parameter int ERR_W      = 8
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  start_i,
    output logic [STEP_W-1:0]     stepIndex_o,
    input  logic [SEQ_BYTE_W-1:0] scriptTx_i,
    input  logic [SEQ_BYTE_W-1:0] scriptExp_i,
    input  logic                  scriptChk_i,
    output logic [SEQ_BYTE_W-1:0] txData_o,
    output logic                  txValid_o,
    input  logic                  txReady_i,
    input  logic [SEQ_BYTE_W-1:0] rxData_i,
    input  logic                  rxValid_i,
    output logic                  rxReady_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  pass_o,
    output logic [ERR_W-1:0]      errCount_o,
    output logic [SEQ_BYTE_W-1:0] lastRx_o,
    output logic                  timedOut_o
);

    localparam int CNT_W = seq_cnt_width(TIMEOUT, GAP_CYCLES);

    seq_state_e              state_q, state_d;
    logic [STEP_W-1:0]       stepIndex_q, stepIndex_d;
    logic [SEQ_BYTE_W-1:0]   txData_q, txData_d;
    logic                    txValid_q, txValid_d;
    logic [SEQ_BYTE_W-1:0]   lastRx_q, lastRx_d;
    logic [ERR_W-1:0]        errCount_q, errCount_d;
    logic                    timedOut_q, timedOut_d;
    logic                    mismatch_q, mismatch_d;
    logic                    lastStep_q, lastStep_d;

    logic                    cntClear, cntEnable, cntTerminal;
    logic [CNT_W-1:0]        cntLimit;
    logic [ERR_W-1:0]        errPlus;
    logic                    isLastStep;

    assign errPlus    = (errCount_q == '1) ? errCount_q : errCount_q + ERR_W'(1);
    assign isLastStep = (stepIndex_q == STEP_W'(NUM_STEPS - 1));

    // The wait counter only runs while a byte is actually offered, so a load cycle never eats into TIMEOUT.
    assign cntClear  = (state_d != state_q);
    assign cntEnable = ((state_q == ST_SEND) && txValid_q) || (state_q == ST_WAIT_RX) || (state_q == ST_GAP);
    assign cntLimit  = (state_q == ST_GAP) ? CNT_W'(GAP_CYCLES) : CNT_W'(TIMEOUT);

    seq_timeout_counter #(.W(CNT_W)) u_waitCounter (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .clear_i    (cntClear),
        .enable_i   (cntEnable),
        .limit_i    (cntLimit),
        .terminal_o (cntTerminal)
    );

    // Compare and advance happen at reply acceptance, so ScriptTx already shows the next step during CHECK
    // and the next byte can be registered on the CHECK->SEND edge without an extra cycle.
    always_comb begin
        state_d     = state_q;
        stepIndex_d = stepIndex_q;
        txData_d    = txData_q;
        txValid_d   = txValid_q;
        lastRx_d    = lastRx_q;
        errCount_d  = errCount_q;
        timedOut_d  = timedOut_q;
        mismatch_d  = mismatch_q;
        lastStep_d  = lastStep_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    state_d     = ST_SEND;
                    stepIndex_d = '0;
                    errCount_d  = '0;
                    timedOut_d  = 1'b0;
                    txValid_d   = 1'b0;
                end
            end
            ST_SEND: begin
                if (!txValid_q) begin
                    txData_d  = scriptTx_i;
                    txValid_d = 1'b1;
                end else if (txReady_i) begin
                    txValid_d = 1'b0;
                    state_d   = ST_WAIT_RX;
                end else if (cntTerminal) begin
                    txValid_d  = 1'b0;
                    timedOut_d = 1'b1;
                    errCount_d = errPlus;
                    state_d    = ST_DONE;
                end
            end
            ST_WAIT_RX: begin
                if (rxValid_i) begin
                    lastRx_d   = rxData_i;
                    mismatch_d = scriptChk_i && (rxData_i != scriptExp_i);
                    lastStep_d = isLastStep;
                    if (!isLastStep) begin
                        stepIndex_d = stepIndex_q + STEP_W'(1);
                    end
                    state_d = ST_CHECK;
                end else if (cntTerminal) begin
                    timedOut_d = 1'b1;
                    errCount_d = errPlus;
                    state_d    = ST_DONE;
                end
            end
            ST_CHECK: begin
                if (mismatch_q) begin
                    errCount_d = errPlus;
                end
                if (lastStep_q) begin
                    state_d = ST_DONE;
                end else if (GAP_CYCLES == 0) begin
                    txData_d  = scriptTx_i;
                    txValid_d = 1'b1;
                    state_d   = ST_SEND;
                end else begin
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (cntTerminal) begin
                    txData_d  = scriptTx_i;
                    txValid_d = 1'b1;
                    state_d   = ST_SEND;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            stepIndex_q <= '0;
            txData_q    <= '0;
            txValid_q   <= 1'b0;
            lastRx_q    <= '0;
            errCount_q  <= '0;
            timedOut_q  <= 1'b0;
            mismatch_q  <= 1'b0;
            lastStep_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            stepIndex_q <= stepIndex_d;
            txData_q    <= txData_d;
            txValid_q   <= txValid_d;
            lastRx_q    <= lastRx_d;
            errCount_q  <= errCount_d;
            timedOut_q  <= timedOut_d;
            mismatch_q  <= mismatch_d;
            lastStep_q  <= lastStep_d;
        end
    end

    assign stepIndex_o = stepIndex_q;
    assign txData_o    = txData_q;
    assign txValid_o   = txValid_q;
    assign rxReady_o   = (state_q == ST_WAIT_RX);
    assign busy_o      = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done_o      = (state_q == ST_DONE);
    assign pass_o      = (state_q == ST_DONE) && (errCount_q == '0) && !timedOut_q;
    assign errCount_o  = errCount_q;
    assign lastRx_o    = lastRx_q;
    assign timedOut_o  = timedOut_q;

endmodule

// File: tb/tb_uart_exchange_sequencer.sv
// Self-checking bench: echo/loopback responder with optional corruption, silence
// and TxReady stall, checked against a step-by-step reference model of a run.
module tb_uart_exchange_sequencer;

    localparam int NSTEPS = 16;
    localparam int STEPW  = 4;
    localparam int TMO    = 500;
    localparam int GAP    = 4;
    localparam int ERRW   = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [STEPW-1:0] stepIndex;
    logic [7:0]       scriptTx, scriptExp;
    logic             scriptChk;
    logic [7:0]       txData;
    logic             txValid;
    logic             txReady = 1'b0;
    logic [7:0]       rxData = 8'h00;
    logic             rxValid = 1'b0;
    logic             rxReady, busy, done, pass, timedOut;
    logic [ERRW-1:0]  errCount;
    logic [7:0]       lastRx;

    logic [7:0] scrTx [NSTEPS];
    logic [7:0] scrExp[NSTEPS];
    logic       scrChk[NSTEPS];

    assign scriptTx  = scrTx[stepIndex];
    assign scriptExp = scrExp[stepIndex];
    assign scriptChk = scrChk[stepIndex];

    always #5 clk = ~clk;

    uart_exchange_sequencer #(
        .NUM_STEPS(NSTEPS), .STEP_W(STEPW), .TIMEOUT(TMO), .GAP_CYCLES(GAP), .ERR_W(ERRW)
    ) dut (
        .clk_i(clk), .reset_i(reset), .start_i(start), .stepIndex_o(stepIndex),
        .scriptTx_i(scriptTx), .scriptExp_i(scriptExp), .scriptChk_i(scriptChk),
        .txData_o(txData), .txValid_o(txValid), .txReady_i(txReady),
        .rxData_i(rxData), .rxValid_i(rxValid), .rxReady_o(rxReady),
        .busy_o(busy), .done_o(done), .pass_o(pass), .errCount_o(errCount),
        .lastRx_o(lastRx), .timedOut_o(timedOut)
    );

    int testCount = 0;
    int failCount = 0;

    // Responder configuration and observations
    int cycle = 0;
    int runTxCount = 0;
    int corruptStep = -1;
    int silentStep = -1;
    int holdLow = 0;
    int maxRxDelay = 0;
    bit randomReady = 0;
    int stepSeenErrs = 0, byteErrs = 0, unstableErrs = 0, rxAccepted = 0, stallCycles = 0;
    int doneRiseCycle = 0;
    int txFireCycle[$];
    logic [7:0] replyQ[$];
    int readyQ[$];
    bit pendTx = 0, pendRx = 0, prevTxValid = 0, prevDone = 0;
    logic [7:0] pendTxByte, prevTxData;
    int pendTxStep;
    bit busyAtPulse;

    // Reference model results
    int expErr, expStep, expTx;
    bit expTimed, expPass, expLastValid;
    logic [7:0] expLast;

    // Handshakes are decided at the negedge and happen at the following posedge, so each
    // negedge first retires the previous decision, then drives inputs for the next edge.
    initial begin
        forever begin
            @(negedge clk);
            cycle++;
            if (reset) begin
                pendTx = 0; pendRx = 0; prevTxValid = 0;
                replyQ.delete(); readyQ.delete();
                txReady = 1'b0; rxValid = 1'b0;
            end else begin
                if (pendTx) begin
                    if (pendTxStep != runTxCount) stepSeenErrs++;
                    txFireCycle.push_back(cycle);
                    if (runTxCount != silentStep) begin
                        replyQ.push_back(pendTxByte + ((runTxCount == corruptStep) ? 8'd1 : 8'd0));
                        readyQ.push_back(cycle + int'($urandom_range(0, maxRxDelay)));
                    end
                    runTxCount++;
                end
                if (pendRx) begin
                    void'(replyQ.pop_front());
                    void'(readyQ.pop_front());
                    rxAccepted++;
                end
                if (prevTxValid && !pendTx && txValid && txData !== prevTxData) unstableErrs++;
                prevTxValid = txValid;
                prevTxData  = txData;
                if (holdLow > 0) begin
                    txReady = 1'b0;
                    holdLow--;
                    if (txValid) stallCycles++;
                end else begin
                    txReady = randomReady ? ($urandom_range(0, 2) != 0) : 1'b1;
                end
                rxValid = (replyQ.size() > 0) && (readyQ[0] <= cycle);
                rxData  = rxValid ? replyQ[0] : 8'($urandom);
                pendTx = txValid && txReady;
                pendTxByte = txData;
                pendTxStep = int'(stepIndex);
                if (pendTx && txData !== scrTx[stepIndex]) byteErrs++;
                pendRx = rxValid && rxReady;
            end
            if (done && !prevDone) doneRiseCycle = cycle;
            prevDone = done;
        end
    end

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    // Walks the script step by step: each step either goes silent (abort) or yields a reply.
    task automatic model();
        logic [7:0] reply;
        expErr = 0; expTimed = 0; expStep = 0; expTx = 0; expLastValid = 0; expLast = 8'h00;
        for (int i = 0; i < NSTEPS; i++) begin
            expStep = i;
            expTx = i + 1;
            if (i == silentStep) begin
                expTimed = 1;
                expErr++;
                break;
            end
            reply = scrTx[i] + ((i == corruptStep) ? 8'd1 : 8'd0);
            expLast = reply;
            expLastValid = 1;
            if (scrChk[i] && reply != scrExp[i]) expErr++;
        end
        expPass = (expErr == 0) && !expTimed;
    endtask

    task automatic runSequence(input int pulseAt);
        bit finished;
        runTxCount = 0; txFireCycle.delete();
        stepSeenErrs = 0; byteErrs = 0; unstableErrs = 0; rxAccepted = 0; stallCycles = 0;
        busyAtPulse = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        finished = 0;
        for (int k = 0; k < 20000 && !finished; k++) begin
            @(negedge clk);
            start = (k == pulseAt);
            if (k == pulseAt) busyAtPulse = busy;
            if (done) finished = 1;
        end
        start = 1'b0;
        if (!finished) begin
            testCount++; failCount++;
            $display("[TB] FAIL run_completion: done=%0b required 1 within 20000 cycles", done);
        end
    endtask

    task automatic loadLoopbackScript();
        for (int i = 0; i < NSTEPS; i++) begin
            scrTx[i] = 8'(i); scrExp[i] = 8'(i); scrChk[i] = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        testCount++; if ({busy, done, pass, timedOut, txValid, rxReady} !== 6'b0) begin failCount++;
            $display("[TB] FAIL reset_flags: busy/done/pass/to/txv/rxr=%b required 000000", {busy, done, pass, timedOut, txValid, rxReady}); end
        testCount++; if (stepIndex !== 4'd0) begin failCount++; $display("[TB] FAIL reset_step: got %0d required 0", stepIndex); end
        testCount++; if (txData !== 8'h00) begin failCount++; $display("[TB] FAIL reset_txdata: got %h required 00", txData); end
        testCount++; if (lastRx !== 8'h00) begin failCount++; $display("[TB] FAIL reset_lastrx: got %h required 00", lastRx); end
        testCount++; if (errCount !== 8'h00) begin failCount++; $display("[TB] FAIL reset_err: got %0d required 0", errCount); end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        testCount++; if (busy !== 1'b0) begin failCount++; $display("[TB] FAIL idle_busy: got %b required 0", busy); end
    endtask

    task automatic test_loopback();
        int gapErrs;
        loadLoopbackScript();
        corruptStep = -1; silentStep = -1; randomReady = 0; maxRxDelay = 0;
        runSequence(-1);
        testCount++; if (!(done === 1'b1 && pass === 1'b1)) begin failCount++; $display("[TB] FAIL loop_done_pass: done=%b pass=%b required 1 1", done, pass); end
        testCount++; if (errCount !== 8'd0) begin failCount++; $display("[TB] FAIL loop_err: got %0d required 0", errCount); end
        testCount++; if (lastRx !== 8'h0F) begin failCount++; $display("[TB] FAIL loop_lastrx: got %h required 0f", lastRx); end
        testCount++; if (stepIndex !== 4'd15) begin failCount++; $display("[TB] FAIL loop_step: got %0d required 15", stepIndex); end
        testCount++; if (txFireCycle.size() != NSTEPS || stepSeenErrs != 0 || byteErrs != 0) begin failCount++;
            $display("[TB] FAIL loop_tx: sent=%0d stepErrs=%0d byteErrs=%0d required 16 0 0", txFireCycle.size(), stepSeenErrs, byteErrs); end
        // Ideal handshakes: one WAIT_RX cycle, one CHECK, GAP idle cycles, one SEND cycle between transfers.
        gapErrs = 0;
        for (int i = 1; i < txFireCycle.size(); i++)
            if (txFireCycle[i] - txFireCycle[i-1] != 3 + GAP) gapErrs++;
        testCount++; if (gapErrs != 0 || txFireCycle.size() < 2) begin failCount++;
            $display("[TB] FAIL loop_gap: %0d intervals differ from required %0d", gapErrs, 3 + GAP); end
    endtask

    task automatic test_mismatch();
        loadLoopbackScript();
        corruptStep = 5; silentStep = -1; randomReady = 1; maxRxDelay = 3;
        runSequence(-1);
        testCount++; if (errCount !== 8'd1) begin failCount++; $display("[TB] FAIL mism_err: got %0d required 1", errCount); end
        testCount++; if (pass !== 1'b0 || done !== 1'b1) begin failCount++; $display("[TB] FAIL mism_pass: pass=%b done=%b required 0 1", pass, done); end
        testCount++; if (txFireCycle.size() != NSTEPS || timedOut !== 1'b0) begin failCount++;
            $display("[TB] FAIL mism_steps: sent=%0d to=%b required 16 0", txFireCycle.size(), timedOut); end
    endtask

    task automatic test_random();
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < NSTEPS; i++) begin
                scrTx[i]  = 8'($urandom);
                scrExp[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : scrTx[i];
                scrChk[i] = ($urandom_range(0, 3) != 0);
            end
            corruptStep = int'($urandom_range(0, NSTEPS)) - 1;
            silentStep = -1; randomReady = 1; maxRxDelay = 6;
            model();
            runSequence(-1);
            testCount++; if (int'(errCount) != expErr || pass !== expPass) begin failCount++;
                $display("[TB] FAIL rand_err[%0d]: err=%0d pass=%b required %0d %b", r, errCount, pass, expErr, expPass); end
            testCount++; if (lastRx !== expLast || int'(stepIndex) != expStep) begin failCount++;
                $display("[TB] FAIL rand_last[%0d]: lastRx=%h step=%0d required %h %0d", r, lastRx, stepIndex, expLast, expStep); end
            testCount++; if (txFireCycle.size() != expTx || rxAccepted != expTx || byteErrs != 0 || stepSeenErrs != 0) begin failCount++;
                $display("[TB] FAIL rand_xfer[%0d]: tx=%0d rx=%0d byteErrs=%0d stepErrs=%0d required %0d %0d 0 0",
                         r, txFireCycle.size(), rxAccepted, byteErrs, stepSeenErrs, expTx, expTx); end
        end
    endtask

    task automatic test_timeout();
        int lat;
        loadLoopbackScript();
        corruptStep = -1; silentStep = 3; randomReady = 1; maxRxDelay = 2;
        model();
        runSequence(-1);
        testCount++; if (timedOut !== 1'b1 || done !== 1'b1 || pass !== 1'b0) begin failCount++;
            $display("[TB] FAIL tmo_flags: to=%b done=%b pass=%b required 1 1 0", timedOut, done, pass); end
        testCount++; if (int'(errCount) != expErr || int'(stepIndex) != expStep) begin failCount++;
            $display("[TB] FAIL tmo_err_step: err=%0d step=%0d required %0d %0d", errCount, stepIndex, expErr, expStep); end
        testCount++; if (txFireCycle.size() != expTx) begin failCount++; $display("[TB] FAIL tmo_sent: got %0d required %0d", txFireCycle.size(), expTx); end
        lat = (txFireCycle.size() > 0) ? doneRiseCycle - txFireCycle[txFireCycle.size()-1] : -1;
        testCount++; if (lat < TMO - 1 || lat > TMO + 2) begin failCount++; $display("[TB] FAIL tmo_latency: got %0d required about %0d", lat, TMO); end
    endtask

    task automatic test_tx_stall();
        loadLoopbackScript();
        corruptStep = -1; silentStep = -1; randomReady = 0; maxRxDelay = 1;
        @(negedge clk); holdLow = 100;
        runSequence(-1);
        testCount++; if (unstableErrs != 0 || stallCycles < 90) begin failCount++;
            $display("[TB] FAIL stall_stable: changes=%0d stalled=%0d required 0 and >=90", unstableErrs, stallCycles); end
        testCount++; if (txFireCycle.size() != NSTEPS || rxAccepted != NSTEPS || pass !== 1'b1) begin failCount++;
            $display("[TB] FAIL stall_count: tx=%0d rx=%0d pass=%b required 16 16 1", txFireCycle.size(), rxAccepted, pass); end
    endtask

    task automatic test_reset_midrun();
        bit reached;
        loadLoopbackScript();
        corruptStep = -1; silentStep = 0; randomReady = 0; maxRxDelay = 0;
        runTxCount = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        reached = 0;
        for (int k = 0; k < 50 && !reached; k++) begin
            @(negedge clk);
            if (rxReady) reached = 1;
        end
        testCount++; if (!reached) begin failCount++; $display("[TB] FAIL mid_waitrx: rxReady=%b required 1 within 50 cycles", rxReady); end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        testCount++; if ({busy, done, pass, timedOut, txValid, rxReady} !== 6'b0 || stepIndex !== 4'd0 || txData !== 8'h00 || errCount !== 8'h00 || lastRx !== 8'h00) begin
            failCount++;
            $display("[TB] FAIL mid_reset: flags=%b step=%0d tx=%h err=%0d last=%h required all 0",
                     {busy, done, pass, timedOut, txValid, rxReady}, stepIndex, txData, errCount, lastRx); end
        reset = 1'b0;
        silentStep = -1;
        runSequence(-1);
        testCount++; if (stepSeenErrs != 0 || txFireCycle.size() != NSTEPS || pass !== 1'b1) begin failCount++;
            $display("[TB] FAIL mid_rerun: stepErrs=%0d tx=%0d pass=%b required 0 16 1", stepSeenErrs, txFireCycle.size(), pass); end
    endtask

    task automatic test_back_to_back();
        loadLoopbackScript();
        corruptStep = 7; silentStep = -1; randomReady = 1; maxRxDelay = 2;
        runSequence(20);
        testCount++; if (busyAtPulse !== 1'b1) begin failCount++; $display("[TB] FAIL b2b_busy: got %b required 1", busyAtPulse); end
        testCount++; if (txFireCycle.size() != NSTEPS || stepSeenErrs != 0 || errCount !== 8'd1) begin failCount++;
            $display("[TB] FAIL b2b_ignored: tx=%0d stepErrs=%0d err=%0d required 16 0 1", txFireCycle.size(), stepSeenErrs, errCount); end
        corruptStep = -1;
        runSequence(-1);
        testCount++; if (errCount !== 8'd0 || pass !== 1'b1 || txFireCycle.size() != NSTEPS) begin failCount++;
            $display("[TB] FAIL b2b_rerun: err=%0d pass=%b tx=%0d required 0 1 16", errCount, pass, txFireCycle.size()); end
    endtask

    initial begin
        for (int i = 0; i < NSTEPS; i++) begin
            scrTx[i] = 8'h00; scrExp[i] = 8'h00; scrChk[i] = 1'b0;
        end
        test_reset();
        test_loopback();
        test_mismatch();
        test_random();
        test_timeout();
        test_tx_stall();
        test_reset_midrun();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
